run_ctrl: RTL and testbench

Run controller for the single-cycle core: sequences one program execution per host request and arbitrates the shared data memory between the host (preload/readback) and the core. It sits between the host interface and the core/dat_mem, driving the core's PC reset and the memory's write-enable/address/data. It also measures run length and optionally enforces a watchdog. Handshake with the host is four-phase req/done.

---
 rtl/run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_run_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl : run controller for the single-cycle core.
//
// Sequences one program execution per host request (four-phase req/done),
// holds the core PC in reset outside a run, arbitrates the shared data memory
// between the host (preload/readback) and the core, measures the run length
// in cycles (saturating) and optionally aborts runaway programs.
//
// Build option:
//   RUN_WDOG_EN  defined   -> watchdog aborts a run when the RUN cycle count
//                             reaches WDOG_LIMIT without a PC match
//                             (timeout is set).
//                undefined -> no watchdog, timeout is always 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset (forces IDLE)
//   req         host start request (level, held until done)
//   host_*      host write strobe / address / data towards data memory
//   core_*      core MemWrite / address / store data towards data memory
//   prog_ctr    core program counter
//   mem_*       muxed write enable / address / data to dat_mem
//   core_rst    active-high hold of the core PC
//   host_gnt    host owns the data memory
//   busy        run in progress (ARM or RUN)
//   done        run finished, held until req drops
//   timeout     last run ended by the watchdog
//   host_err    sticky: host write attempted while not granted
//   cycles      RUN cycles of the current/last run, saturating
// -----------------------------------------------------------------------------
module run_ctrl #(
  parameter int unsigned     D          = 12,
  parameter logic [D-1:0]    DONE_PC    = 12'd128,
  parameter int unsigned     CW         = 16,
  parameter logic [CW-1:0]   WDOG_LIMIT = 16'hFFF0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          host_wr_en,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_wdata,
  input  logic          core_wr_en,
  input  logic [7:0]    core_addr,
  input  logic [7:0]    core_wdata,
  input  logic [D-1:0]  prog_ctr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          core_rst,
  output logic          host_gnt,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          host_err,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cycles_r;
  logic [CW-1:0] cyc_inc_s;
  logic          timeout_r;
  logic          host_err_r;
  logic          pc_hit_s;
  logic          wdog_hit_s;

  // Saturating increment of the run-length counter.
  always_comb begin
    if (cycles_r == {CW{1'b1}}) begin
      cyc_inc_s = cycles_r;
    end else begin
      cyc_inc_s = cycles_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign pc_hit_s = (prog_ctr == DONE_PC);

`ifdef RUN_WDOG_EN
  // Compare against the count this cycle will produce, so a limit of N
  // ends the run with cycles == N.
  assign wdog_hit_s = (cyc_inc_s == WDOG_LIMIT);
`else
  logic unused_wdog_s;
  assign wdog_hit_s    = 1'b0;
  assign unused_wdog_s = ^WDOG_LIMIT;
`endif

  // Status outputs are pure decodes of the state register.
  assign core_rst = (state_r != ST_RUN);
  assign host_gnt = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign busy     = (state_r == ST_ARM) || (state_r == ST_RUN);
  assign done     = (state_r == ST_DONE);
  assign timeout  = timeout_r;
  assign host_err = host_err_r;
  assign cycles   = cycles_r;

  // Data memory mux: host when granted, core only while running (ARM blocks writes).
  always_comb begin
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wr_en = host_wr_en;
    end else begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_wr_en = (state_r == ST_RUN) ? core_wr_en : 1'b0;
    end
  end

  // Run sequencer: state, run-length counter, watchdog flag and host error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cycles_r   <= {CW{1'b0}};
      timeout_r  <= 1'b0;
      host_err_r <= 1'b0;
    end else begin
      // A dropped host write is reported even if it lands in ARM.
      if (host_wr_en && !host_gnt) begin
        host_err_r <= 1'b1;
      end else if (state_r == ST_ARM) begin
        host_err_r <= 1'b0;
      end else begin
        host_err_r <= host_err_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (req) begin
            state_r <= ST_ARM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARM: begin
          cycles_r  <= {CW{1'b0}};
          timeout_r <= 1'b0;
          state_r   <= ST_RUN;
        end
        ST_RUN: begin
          cycles_r <= cyc_inc_s;
          // PC match wins over a simultaneous watchdog hit.
          if (pc_hit_s) begin
            timeout_r <= 1'b0;
            state_r   <= ST_DONE;
          end else if (wdog_hit_s) begin
            timeout_r <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            state_r   <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (!req) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        host_wr_en;
  logic [7:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        core_wr_en;
  logic [7:0]  core_addr;
  logic [7:0]  core_wdata;
  logic [11:0] prog_ctr;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        core_rst;
  logic        host_gnt;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        host_err;
  logic [15:0] cycles;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  int run_cnt;

  // Stand-in for dat_mem.
  logic [7:0] mem [0:255];

  run_ctrl #(
    .D(12), .DONE_PC(12'd128), .CW(16), .WDOG_LIMIT(16'd100)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdata(host_wdata),
    .core_wr_en(core_wr_en), .core_addr(core_addr), .core_wdata(core_wdata),
    .prog_ctr(prog_ctr),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .host_gnt(host_gnt), .busy(busy), .done(done),
    .timeout(timeout), .host_err(host_err), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0;
    host_wr_en = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    core_wr_en = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    prog_ctr = 12'd0;

    // Reset state
    #12;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_host_gnt", 32'(host_gnt), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);
    chk("rst_host_err", 32'(host_err), 32'd0);
    chk("rst_cycles",   32'(cycles),   32'd0);
    reset = 1'b1;
    tick();

    // Host preload while idle
    host_wr_en = 1'b1; host_addr = 8'h05; host_wdata = 8'hA5;
    #1;
    chk("idle_mux_we",   32'(mem_wr_en), 32'd1);
    chk("idle_mux_addr", 32'(mem_addr),  32'h05);
    chk("idle_mux_data", 32'(mem_wdata), 32'hA5);
    tick();
    chk("mem05", 32'(mem[8'h05]), 32'hA5);
    host_addr = 8'h10; host_wdata = 8'h77;
    tick();
    host_wr_en = 1'b0;
    chk("mem10_pre", 32'(mem[8'h10]), 32'h77);

    // Run 1: PC match on the 40th RUN cycle
    req = 1'b1;
    tick();
    chk("arm_busy",     32'(busy),     32'd1);
    chk("arm_core_rst", 32'(core_rst), 32'd1);
    chk("arm_host_gnt", 32'(host_gnt), 32'd0);
    busy_cnt = 0; run_cnt = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      busy_cnt++;
      if (!core_rst) begin
        run_cnt++;
        prog_ctr = (run_cnt == 40) ? 12'd128 : 12'(run_cnt);
      end
      tick();
    end
    chk("r1_busy_cnt", 32'(busy_cnt), 32'd41);
    chk("r1_done",     32'(done),     32'd1);
    chk("r1_cycles",   32'(cycles),   32'd40);
    chk("r1_timeout",  32'(timeout),  32'd0);
    chk("r1_host_gnt", 32'(host_gnt), 32'd1);
    chk("r1_core_rst", 32'(core_rst), 32'd1);
    req = 1'b0; prog_ctr = 12'd0;
    tick();
    chk("r1_done_clr", 32'(done), 32'd0);
    chk("r1_idle_gnt", 32'(host_gnt), 32'd1);

    // Run 2: host write while not granted, core write pass-through
    req = 1'b1;
    tick();
    tick();
    chk("r2_run_core_rst", 32'(core_rst), 32'd0);
    host_wr_en = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
    #1;
    chk("r2_host_blocked", 32'(mem_wr_en), 32'd0);
    tick();
    host_wr_en = 1'b0;
    chk("r2_host_err", 32'(host_err), 32'd1);
    chk("r2_mem10",    32'(mem[8'h10]), 32'h77);
    core_wr_en = 1'b1; core_addr = 8'h20; core_wdata = 8'h3C;
    #1;
    chk("r2_core_we",   32'(mem_wr_en), 32'd1);
    chk("r2_core_addr", 32'(mem_addr),  32'h20);
    tick();
    core_wr_en = 1'b0;
    chk("r2_mem20", 32'(mem[8'h20]), 32'h3C);
    prog_ctr = 12'd128;
    tick();
    prog_ctr = 12'd0;
    chk("r2_done",     32'(done),     32'd1);
    chk("r2_err_held", 32'(host_err), 32'd1);
    chk("r2_cycles",   32'(cycles),   32'd3);
    req = 1'b0;
    tick();
    chk("r2_err_idle", 32'(host_err), 32'd1);

    // Run 3: ARM blocks writes, clears host_err; req dropped mid-run
    req = 1'b1;
    tick();
    core_wr_en = 1'b1;
    #1;
    chk("r3_arm_we_blk", 32'(mem_wr_en), 32'd0);
    chk("r3_arm_err",    32'(host_err),  32'd1);
    core_wr_en = 1'b0;
    tick();
    chk("r3_err_clr", 32'(host_err), 32'd0);
    chk("r3_cyc0",    32'(cycles),   32'd0);
    req = 1'b0;
    tick();
    tick();
    chk("r3_busy_noreq", 32'(busy), 32'd1);
    prog_ctr = 12'd128;
    tick();
    prog_ctr = 12'd0;
    chk("r3_done",   32'(done),   32'd1);
    chk("r3_cycles", 32'(cycles), 32'd3);
    tick();
    chk("r3_done_pulse", 32'(done), 32'd0);
    chk("r3_idle_busy",  32'(busy), 32'd0);

    // Run 4: asynchronous reset 20 cycles into RUN
    req = 1'b1;
    tick();
    tick();
    repeat (20) tick();
    chk("r4_cyc20", 32'(cycles), 32'd20);
    #2;
    reset = 1'b0;
    #1;
    chk("r4_areset_busy",     32'(busy),     32'd0);
    chk("r4_areset_core_rst", 32'(core_rst), 32'd1);
    chk("r4_areset_gnt",      32'(host_gnt), 32'd1);
    chk("r4_areset_cycles",   32'(cycles),   32'd0);
    req = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    req = 1'b1;
    tick();
    chk("r5_arm_busy", 32'(busy), 32'd1);
    tick();
    prog_ctr = 12'd128;
    tick();
    prog_ctr = 12'd0;
    chk("r5_done",   32'(done),   32'd1);
    chk("r5_cycles", 32'(cycles), 32'd1);
    req = 1'b0;
    tick();

`ifdef RUN_WDOG_EN
    // Watchdog abort at limit 100
    req = 1'b1;
    tick();
    tick();
    repeat (99) tick();
    chk("wd_busy99", 32'(busy), 32'd1);
    tick();
    chk("wd_done",    32'(done),    32'd1);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_cycles",  32'(cycles),  32'd100);
    req = 1'b0;
    tick();
    // Match on the same cycle as the limit: normal completion
    req = 1'b1;
    tick();
    tick();
    chk("wd2_timeout_clr", 32'(timeout), 32'd0);
    repeat (99) tick();
    prog_ctr = 12'd128;
    tick();
    prog_ctr = 12'd0;
    chk("wd2_done",    32'(done),    32'd1);
    chk("wd2_timeout", 32'(timeout), 32'd0);
    chk("wd2_cycles",  32'(cycles),  32'd100);
    req = 1'b0;
    tick();
`else
    // No watchdog: run continues past the limit
    req = 1'b1;
    tick();
    tick();
    repeat (110) tick();
    chk("nowd_busy",    32'(busy),    32'd1);
    chk("nowd_timeout", 32'(timeout), 32'd0);
    chk("nowd_cycles",  32'(cycles),  32'd110);
    prog_ctr = 12'd128;
    tick();
    prog_ctr = 12'd0;
    chk("nowd_done",   32'(done),   32'd1);
    chk("nowd_cycles2", 32'(cycles), 32'd111);
    req = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
